// File: rtl/npc_seq.sv
// npc_seq: multi-cycle fetch / exec / mem / write-back sequencer for the NPC core.
// Owns pc, the instruction register and the retire counter, and halts the core on
// ebreak, an unknown instruction, a misaligned next pc or a handshake timeout.
module npc_seq #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid,
  output logic [63:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  input  logic        dec_unknown,
  input  logic [63:0] next_pc,
  output logic        ls_req_valid,
  input  logic        ls_req_ready,
  input  logic        ls_rsp_valid,
  output logic        reg_wen_gate,
  output logic [63:0] pc,
  output logic        retire,
  output logic [63:0] instret,
  output logic        halted,
  output logic [1:0]  err_code
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [ILEN-1:0]  NOP_INST = ILEN'(32'h0000_0013);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN = 2'd1;
  localparam logic [1:0] ERR_ALIGN   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_q;
  logic             is_store_q;

  logic             inst_ld;
  logic             pc_ld;
  logic             cnt_inc;
  logic             retire_d;
  logic             store_set;
  logic             store_clr;
  logic             tmo_clr;
  logic             tmo_inc;
  logic [1:0]       err_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-control decode.
  always_comb begin
    state_d   = state_q;
    inst_ld   = 1'b0;
    pc_ld     = 1'b0;
    cnt_inc   = 1'b0;
    retire_d  = 1'b0;
    store_set = 1'b0;
    store_clr = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    err_d     = err_code;

    case (state_q)
      FETCH_REQ: begin
        if (if_req_ready) begin
          state_d = FETCH_WAIT;
          tmo_clr = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (if_rsp_valid) begin
          inst_ld = 1'b1;
          state_d = EXEC;
        end else if (tmo_q == TMO_LAST) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      EXEC: begin
        if (dec_unknown) begin
          state_d = HALT;
          err_d   = ERR_UNKNOWN;
        end else if (dec_ebreak) begin
          retire_d = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = HALT;
          err_d    = ERR_NONE;
        end else if (dec_load || dec_store) begin
          store_set = 1'b1;
          state_d   = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        if (ls_req_ready) begin
          state_d = MEM_WAIT;
          tmo_clr = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (ls_rsp_valid) begin
          state_d = WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WB: begin
        cnt_inc   = 1'b1;
        pc_ld     = 1'b1;
        store_clr = 1'b1;
        if (next_pc[1:0] != 2'b00) begin
          state_d = HALT;
          err_d   = ERR_ALIGN;
        end else begin
          state_d = FETCH_REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    // retire is registered, so it is raised for the cycle spent in WB
    if (state_d == WB) begin
      retire_d = 1'b1;
    end
  end

  // Architectural registers and handshake timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      instret    <= '0;
      err_code   <= ERR_NONE;
      tmo_q      <= '0;
      is_store_q <= 1'b0;
      retire     <= 1'b0;
    end else begin
      retire   <= retire_d;
      err_code <= err_d;
      if (pc_ld) begin
        pc <= next_pc;
      end
      if (inst_ld) begin
        inst <= if_rsp_data;
      end
      if (cnt_inc) begin
        instret <= instret + XLEN'(1);
      end
      if (store_set) begin
        is_store_q <= dec_store;
      end else if (store_clr) begin
        is_store_q <= 1'b0;
      end
      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (tmo_inc && (tmo_q != TMO_MAX)) begin
        tmo_q <= tmo_q + CNT_W'(1);
      end
    end
  end

  // Handshake and status outputs decoded from the state register; the fetch
  // request is masked while reset is held so every output reads its reset value.
  assign if_req_valid = rst_n && (state_q == FETCH_REQ);
  assign if_req_addr  = pc;
  assign ls_req_valid = (state_q == MEM_REQ);
  assign reg_wen_gate = (state_q == WB) && !is_store_q;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed bench for npc_seq with a behavioural reference model,
// a per-cycle compare process, and simple fetch / load-store responders.
module tb_npc_seq;

  localparam int unsigned TO     = 16;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_LW   = 32'h0002_a283;
  localparam logic [31:0] I_SD   = 32'h0012_b023;
  localparam logic [31:0] I_EBRK = 32'h0010_0073;
  localparam logic [31:0] I_BAD  = 32'hffff_ffff;

  localparam int P_FREQ  = 0;
  localparam int P_FWAIT = 1;
  localparam int P_EX    = 2;
  localparam int P_MREQ  = 3;
  localparam int P_MWAIT = 4;
  localparam int P_WB    = 5;
  localparam int P_HLT   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready = 1'b1;
  logic        if_rsp_valid = 1'b0;
  logic [31:0] if_rsp_data = 32'h0;
  logic [31:0] inst;
  logic        dec_load, dec_store, dec_ebreak, dec_unknown;
  logic [63:0] next_pc;
  logic        ls_req_valid;
  logic        ls_req_ready = 1'b0;
  logic        ls_rsp_valid = 1'b0;
  logic        reg_wen_gate;
  logic [63:0] pc;
  logic        retire;
  logic [63:0] instret;
  logic        halted;
  logic [1:0]  err_code;

  logic [31:0] f_word = NOP;
  logic [63:0] np_v = 64'h0;
  int          l_delay = 0;
  logic        f_mute = 1'b0;
  logic        l_mute = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  npc_seq #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .inst(inst),
    .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak), .dec_unknown(dec_unknown),
    .next_pc(next_pc),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid),
    .reg_wen_gate(reg_wen_gate), .pc(pc), .retire(retire), .instret(instret),
    .halted(halted), .err_code(err_code)
  );

  // Tiny stand-in decoder: recognises only the opcodes the bench uses.
  function automatic logic f_load(input logic [31:0] w);
    return w[6:0] == 7'h03;
  endfunction
  function automatic logic f_store(input logic [31:0] w);
    return w[6:0] == 7'h23;
  endfunction
  function automatic logic f_ebreak(input logic [31:0] w);
    return w == I_EBRK;
  endfunction
  function automatic logic f_unknown(input logic [31:0] w);
    return w == I_BAD;
  endfunction

  assign dec_load    = f_load(inst);
  assign dec_store   = f_store(inst);
  assign dec_ebreak  = f_ebreak(inst);
  assign dec_unknown = f_unknown(inst);
  assign next_pc     = np_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fetch responder: answers one cycle after an accepted request.
  logic fhs;
  always begin
    @(negedge clk);
    fhs = rst_n && if_req_valid && if_req_ready;
    @(posedge clk);
    #1;
    if_rsp_valid = fhs && !f_mute;
    if_rsp_data  = (fhs && !f_mute) ? f_word : 32'h0;
  end

  // Load/store responder: ready after l_delay waiting cycles, response one cycle later.
  logic lhs;
  int   vcnt = 0;
  always begin
    @(negedge clk);
    lhs = rst_n && ls_req_valid && ls_req_ready;
    @(posedge clk);
    #1;
    ls_rsp_valid = lhs && !l_mute;
    if (lhs) begin
      ls_req_ready = 1'b0;
      vcnt = 0;
    end else if (ls_req_valid) begin
      vcnt++;
      ls_req_ready = (vcnt > l_delay);
    end else begin
      vcnt = 0;
      ls_req_ready = 1'b0;
    end
  end

  // Reference model: instruction phases advanced by the handshake rules.
  int          m_ph;
  int          m_wait;
  logic [63:0] m_pc, m_cnt;
  logic [31:0] m_inst;
  logic [1:0]  m_err;
  logic        m_ret, m_store;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_FREQ; m_wait = 0; m_pc = RST_PC; m_cnt = 0;
      m_inst = NOP; m_err = 0; m_ret = 0; m_store = 0;
    end else begin
      m_ret = 0;
      case (m_ph)
        P_FREQ: if (if_req_ready) begin m_ph = P_FWAIT; m_wait = 0; end
        P_FWAIT: begin
          if (if_rsp_valid) begin
            m_inst = if_rsp_data; m_ph = P_EX;
          end else begin
            m_wait++;
            if (m_wait >= TO) begin m_ph = P_HLT; m_err = 3; end
          end
        end
        P_EX: begin
          if (f_unknown(m_inst)) begin m_ph = P_HLT; m_err = 1; end
          else if (f_ebreak(m_inst)) begin m_cnt++; m_ret = 1; m_ph = P_HLT; m_err = 0; end
          else if (f_load(m_inst) || f_store(m_inst)) begin m_store = f_store(m_inst); m_ph = P_MREQ; end
          else m_ph = P_WB;
        end
        P_MREQ: if (ls_req_ready) begin m_ph = P_MWAIT; m_wait = 0; end
        P_MWAIT: begin
          if (ls_rsp_valid) m_ph = P_WB;
          else begin
            m_wait++;
            if (m_wait >= TO) begin m_ph = P_HLT; m_err = 3; end
          end
        end
        P_WB: begin
          m_cnt++; m_pc = next_pc; m_store = 0;
          if (next_pc[1:0] != 2'b00) begin m_ph = P_HLT; m_err = 2; end
          else m_ph = P_FREQ;
        end
        default: m_ph = P_HLT;
      endcase
      if (m_ph == P_WB) m_ret = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("if_req_valid", 64'(if_req_valid), 64'(rst_n && (m_ph == P_FREQ)));
    chk("if_req_addr",  if_req_addr, m_pc);
    chk("ls_req_valid", 64'(ls_req_valid), 64'(m_ph == P_MREQ));
    chk("reg_wen_gate", 64'(reg_wen_gate), 64'((m_ph == P_WB) && !m_store));
    chk("pc",           pc, m_pc);
    chk("inst",         64'(inst), 64'(m_inst));
    chk("instret",      instret, m_cnt);
    chk("retire",       64'(retire), 64'(m_ret));
    chk("halted",       64'(halted), 64'(m_ph == P_HLT));
    chk("err_code",     64'(err_code), 64'(m_err));
  end

  task automatic rst_vals(input string tag);
    chk({tag, "_pc"},      pc, RST_PC);
    chk({tag, "_inst"},    64'(inst), 64'(NOP));
    chk({tag, "_instret"}, instret, 64'h0);
    chk({tag, "_err"},     64'(err_code), 64'h0);
    chk({tag, "_ifv"},     64'(if_req_valid), 64'h0);
    chk({tag, "_lsv"},     64'(ls_req_valid), 64'h0);
    chk({tag, "_wen"},     64'(reg_wen_gate), 64'h0);
    chk({tag, "_ret"},     64'(retire), 64'h0);
    chk({tag, "_halt"},    64'(halted), 64'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; f_mute = 1'b0; l_mute = 1'b0;
    #2;
    rst_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH_REQ until it retires or the core halts.
  task automatic run_one(input logic [31:0] w, input logic [63:0] np, input int ld,
                         output int lsv, output logic wen);
    logic done;
    f_word = w; np_v = np; l_delay = ld; lsv = 0; wen = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (ls_req_valid) lsv++;
      if (reg_wen_gate) wen = 1'b1;
      if (retire || halted) done = 1'b1;
    end
    chk("run_done", 64'(done), 64'h1);
    if (done && !halted) @(negedge clk);
  endtask

  int   lsv;
  logic wen;
  logic seen;
  int   n;

  initial begin
    do_reset();

    // addi: 4-cycle path, literal cycle positions
    f_word = I_ADDI; np_v = 64'h8000_0004;
    @(negedge clk);
    chk("a_ifv_c1", 64'(if_req_valid), 64'h1);
    chk("a_addr_c1", if_req_addr, 64'h8000_0000);
    repeat (3) @(negedge clk);
    chk("a_wen_c4", 64'(reg_wen_gate), 64'h1);
    chk("a_ret_c4", 64'(retire), 64'h1);
    @(negedge clk);
    chk("a_pc", pc, 64'h8000_0004);
    chk("a_instret", instret, 64'h1);

    // lw with ready delayed 3 cycles
    run_one(I_LW, 64'h8000_0008, 3, lsv, wen);
    chk("lw_lsv_cycles", 64'(lsv), 64'd4);
    chk("lw_wen", 64'(wen), 64'h1);
    chk("lw_instret", instret, 64'd2);

    // sd: no register write
    run_one(I_SD, 64'h8000_000c, 0, lsv, wen);
    chk("sd_lsv_cycles", 64'(lsv), 64'd1);
    chk("sd_wen", 64'(wen), 64'h0);
    chk("sd_instret", instret, 64'd3);

    // ebreak retires then halts cleanly
    run_one(I_EBRK, 64'h8000_0010, 0, lsv, wen);
    chk("eb_halted", 64'(halted), 64'h1);
    chk("eb_err", 64'(err_code), 64'h0);
    chk("eb_instret", instret, 64'd4);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if_req_valid) seen = 1'b1;
    end
    chk("eb_no_fetch", 64'(seen), 64'h0);
    chk("eb_pc_hold", pc, 64'h8000_000c);

    // unknown instruction
    do_reset();
    run_one(I_BAD, 64'h8000_0004, 0, lsv, wen);
    chk("unk_halted", 64'(halted), 64'h1);
    chk("unk_err", 64'(err_code), 64'd1);
    chk("unk_instret", instret, 64'd0);

    // misaligned next pc
    do_reset();
    run_one(I_ADDI, 64'h8000_0002, 0, lsv, wen);
    chk("mis_halted", 64'(halted), 64'h1);
    chk("mis_err", 64'(err_code), 64'd2);
    chk("mis_pc", pc, 64'h8000_0002);
    chk("mis_instret", instret, 64'd1);

    // fetch timeout: 1 FETCH_REQ cycle + TO waiting cycles before HALT
    do_reset();
    f_mute = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted) break;
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'(TO + 1));
    chk("tmo_err", 64'(err_code), 64'd3);

    // reset pulse in the middle of MEM_WAIT
    do_reset();
    run_one(I_ADDI, 64'h8000_0004, 0, lsv, wen);
    chk("e_instret", instret, 64'd1);
    l_mute = 1'b1; f_word = I_LW; np_v = 64'h8000_0008; l_delay = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ls_req_valid) seen = 1'b1;
    end
    chk("e_mem_req", 64'(seen), 64'h1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1; l_mute = 1'b0;
    @(negedge clk);
    chk("e_refetch_v", 64'(if_req_valid), 64'h1);
    chk("e_refetch_a", if_req_addr, 64'h8000_0000);
    run_one(I_ADDI, 64'h8000_0004, 0, lsv, wen);
    chk("e2_instret", instret, 64'd1);
    chk("e2_pc", pc, 64'h8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/npc_seq.md
# npc_seq

Multi-cycle sequencer for the NPC core. It owns the PC and the instruction register, and drives the fetch and load/store handshakes. It steps each instruction through fetch, decode/execute, memory and write-back, with the combinational decoder sitting between the instruction register and this block's decode-flag inputs. It also gates register-file writes, counts retired instructions and halts the core on ebreak, an unknown instruction, a misaligned PC or a memory timeout.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC value loaded on reset.
- `TIMEOUT`, default 255: maximum cycles spent waiting in FETCH_WAIT or MEM_WAIT before an error.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req_valid` out 1: fetch request valid.
- `if_req_addr` out 64: fetch address, equal to `pc`.
- `if_req_ready` in 1: fetch request accepted.
- `if_rsp_valid` in 1: fetch response valid.
- `if_rsp_data` in 32: fetched instruction.
- `inst` out 32: instruction register, feeds the decoder.
- `dec_load` in 1: decoder reports a load.
- `dec_store` in 1: decoder reports a store.
- `dec_ebreak` in 1: decoder reports ebreak.
- `dec_unknown` in 1: decoder reports an unknown instruction (nonzero unknown-code).
- `next_pc` in 64: next PC from the branch/jump unit, valid in EXEC and WB.
- `ls_req_valid` out 1: load/store request valid.
- `ls_req_ready` in 1: load/store request accepted.
- `ls_rsp_valid` in 1: load data returned, or store completed.
- `reg_wen_gate` out 1: qualifies the decoder's reg_wen for the register file.
- `pc` out 64: current PC.
- `retire` out 1: one-cycle pulse per retired instruction.
- `instret` out 64: count of retired instructions.
- `halted` out 1: core stopped.
- `err_code` out 2: 0 = none, 1 = unknown instruction, 2 = misaligned PC, 3 = timeout.

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset values: state = FETCH_REQ, `pc` = RESET_PC, `inst` = 32'h0000_0013 (nop), `instret` = 0, `err_code` = 0, timeout counter = 0. All other outputs are 0 (`if_req_valid`, `ls_req_valid`, `reg_wen_gate`, `retire`, `halted`).
- FETCH_REQ:
  - `if_req_valid` = 1, with `if_req_addr` stable until accepted.
  - Move to FETCH_WAIT on `if_req_valid & if_req_ready`.
- FETCH_WAIT:
  - On `if_rsp_valid`, latch `inst` ← `if_rsp_data` and move to EXEC.
  - `if_rsp_valid` is ignored in every other state.
- EXEC: priority is unknown > ebreak > memory > ALU.
  - `dec_unknown`: go to HALT with `err_code` = 1.
  - `dec_ebreak`: pulse `retire`, increment `instret`, go to HALT with `err_code` = 0.
  - `dec_load | dec_store`: latch `is_store` = `dec_store`, go to MEM_REQ.
  - Otherwise: go to WB.
- MEM_REQ: `ls_req_valid` = 1 until `ls_req_ready`, then go to MEM_WAIT.
- MEM_WAIT: on `ls_rsp_valid`, go to WB.
- WB: one cycle.
  - `reg_wen_gate` = `!is_store`.
  - `retire` = 1 and `instret` += 1 (wraps modulo 2^64).
  - `pc` ← `next_pc`; clear `is_store`; go to FETCH_REQ.
  - If `next_pc[1:0]` != 0: `pc` still updates and the instruction still retires, but go to HALT with `err_code` = 2.
- Timeout:
  - The counter clears on entry to FETCH_WAIT or MEM_WAIT and increments on each waiting cycle.
  - When it reaches TIMEOUT without a response, go to HALT with `err_code` = 3.
  - The counter saturates and does not wrap.
- HALT:
  - `halted` = 1; the state is terminal until reset.
  - No requests are issued, `pc` and `instret` hold, and `err_code` holds.
- `reg_wen_gate` is 0 in every state except WB.

## Timing
- Outputs are decoded from the registered state. `pc`, `inst` and `instret` are registers.
- Minimum latency with ready and response one cycle after the request:
  - ALU or jump instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load or store: 6 cycles.
- A response in the same cycle as request acceptance is not accepted. A response is sampled only in the WAIT state.
- `ls_req_ready` arriving together with an already-asserted `ls_req_valid` completes the handshake in that cycle.
- Reset asserted mid-instruction: all registers return to their reset values immediately (asynchronously). Responses arriving after reset deassertion are dropped unless the block is in FETCH_WAIT.
- `halted` rises in the cycle after the EXEC or WB decision that triggers the halt.

## Test plan
- Reset release; `if_req_ready` = 1; response `addi` (32'h00100093) on the next cycle; `next_pc` = 0x8000_0004 → `if_req_addr` = 0x8000_0000; `reg_wen_gate` and `retire` high in cycle 4; `pc` = 0x8000_0004; `instret` = 1.
- `lw` with `ls_req_ready` delayed 3 cycles → `ls_req_valid` held for 4 cycles; `reg_wen_gate` = 1 in WB; `instret` increments once.
- `sd` (`dec_store`) → `reg_wen_gate` stays 0 through WB; `retire` = 1.
- `inst` = 32'h0010_0073 with `dec_ebreak` → `halted` = 1, `err_code` = 0, `instret` incremented; no further `if_req_valid`.
- `dec_unknown` → `halted` = 1, `err_code` = 1. Separately, `next_pc` = 0x8000_0002 in WB → `err_code` = 2, `pc` = 0x8000_0002.
- No fetch response for TIMEOUT cycles → `err_code` = 3. Then pulse `rst_n` low mid-MEM_WAIT → all outputs return to reset values asynchronously and fetch restarts at 0x8000_0000.
